// File: rtl/filt_axi_bridge.sv
// AXI4-Lite slave driving the strobe/toggle-ack register protocol of the sobel pipeline:
// writes become coefficient requests, reads become histogram-bin requests.
module filt_axi_bridge #(
  parameter int TIMEOUT    = 4096,
  parameter int STROBE_LOW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [8:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [7:0]  fir_addr_o,
  output logic [31:0] fir_coeff_o,
  output logic        wr_strobe_o,
  input  logic        wr_ack_i,
  output logic        rd_strobe_o,
  input  logic        rd_ack_i,
  input  logic [31:0] hist_bin_i
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int LCW = $clog2(STROBE_LOW + 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_wr_sync;
  logic [1:0]       r_rd_sync;
  logic             r_wr_ack_ref;
  logic             r_rd_ack_ref;
  logic [WCW-1:0]   r_wait_cnt;
  logic [LCW-1:0]   r_low_cnt;
  logic [15:0]      r_timeout_cnt;
  logic [7:0]       r_fir_addr;
  logic [31:0]      r_fir_coeff;
  logic [1:0]       r_bresp;
  logic [1:0]       r_rresp;
  logic [31:0]      r_rdata;
  logic             r_wr_strobe;
  logic             r_rd_strobe;

  logic             w_wr_accept;
  logic             w_rd_accept;
  logic             w_wr_ack;
  logic             w_rd_ack;
  logic             w_wait_done;
  logic             w_aw_window;
  logic             w_ar_window;
  logic             w_ar_status;
  logic [31:0]      w_status;

  assign w_aw_window = ~s_axi_awaddr[8];
  assign w_ar_window = ~s_axi_araddr[8];
  assign w_ar_status = (s_axi_araddr == 9'h100);
  assign w_wr_ack    = r_wr_sync[1] ^ r_wr_ack_ref;
  assign w_rd_ack    = r_rd_sync[1] ^ r_rd_ack_ref;
  assign w_wait_done = (r_wait_cnt == WCW'(TIMEOUT - 1));
  assign w_status    = {r_timeout_cnt, 14'b0, r_state == RD_REQ, r_state == WR_REQ};

  // A write request wins over a simultaneous read request.
  assign w_wr_accept = (r_state == IDLE) && s_axi_awvalid && s_axi_wvalid && (r_low_cnt == '0);
  assign w_rd_accept = (r_state == IDLE) && !(s_axi_awvalid && s_axi_wvalid) &&
                       s_axi_arvalid && (r_low_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_accept)      w_state_next = w_aw_window ? WR_REQ : WR_RESP;
        else if (w_rd_accept) w_state_next = w_ar_window ? RD_REQ : RD_RESP;
      end
      WR_REQ:  if (w_wr_ack || w_wait_done) w_state_next = WR_RESP;
      RD_REQ:  if (w_rd_ack || w_wait_done) w_state_next = RD_RESP;
      WR_RESP: if (s_axi_bready) w_state_next = IDLE;
      RD_RESP: if (s_axi_rready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_wr_sync     <= '0;
      r_rd_sync     <= '0;
      r_wr_ack_ref  <= 1'b0;
      r_rd_ack_ref  <= 1'b0;
      r_wait_cnt    <= '0;
      r_low_cnt     <= '0;
      r_timeout_cnt <= '0;
      r_fir_addr    <= '0;
      r_fir_coeff   <= '0;
      r_bresp       <= RESP_OKAY;
      r_rresp       <= RESP_OKAY;
      r_rdata       <= '0;
      r_wr_strobe   <= 1'b0;
      r_rd_strobe   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wr_sync   <= {r_wr_sync[0], wr_ack_i};
      r_rd_sync   <= {r_rd_sync[0], rd_ack_i};
      // Strobes are registered decodes so the async pipeline never sees a glitch.
      r_wr_strobe <= (w_state_next == WR_REQ);
      r_rd_strobe <= (w_state_next == RD_REQ);

      if (r_state == WR_REQ || r_state == RD_REQ) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                        r_wait_cnt <= '0;

      if ((r_wr_strobe && w_state_next != WR_REQ) || (r_rd_strobe && w_state_next != RD_REQ))
        r_low_cnt <= LCW'(STROBE_LOW - 1);
      else if (r_low_cnt != '0)
        r_low_cnt <= r_low_cnt - 1'b1;

      if (w_wr_accept) begin
        r_bresp      <= RESP_OKAY;
        r_wr_ack_ref <= r_wr_sync[1];
        if (w_aw_window) begin
          r_fir_addr  <= s_axi_awaddr[7:0];
          r_fir_coeff <= s_axi_wdata;
        end
      end

      if (w_rd_accept) begin
        r_rd_ack_ref <= r_rd_sync[1];
        if (!w_ar_window) begin
          r_rdata <= w_ar_status ? w_status : 32'h0;
          r_rresp <= w_ar_status ? RESP_OKAY : RESP_SLVERR;
        end
      end

      if (r_state == WR_REQ) begin
        if (w_wr_ack) begin
          r_bresp <= RESP_OKAY;
        end else if (w_wait_done) begin
          r_bresp <= RESP_SLVERR;
          if (r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
      end

      if (r_state == RD_REQ) begin
        if (w_rd_ack) begin
          r_rdata <= hist_bin_i;
          r_rresp <= RESP_OKAY;
        end else if (w_wait_done) begin
          r_rdata <= 32'h0;
          r_rresp <= RESP_SLVERR;
          if (r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
      end
    end
  end

  assign s_axi_awready = w_wr_accept;
  assign s_axi_wready  = w_wr_accept;
  assign s_axi_arready = w_rd_accept;
  assign s_axi_bvalid  = (r_state == WR_RESP);
  assign s_axi_rvalid  = (r_state == RD_RESP);
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;
  assign fir_addr_o    = r_fir_addr;
  assign fir_coeff_o   = r_fir_coeff;
  assign wr_strobe_o   = r_wr_strobe;
  assign rd_strobe_o   = r_rd_strobe;

endmodule
